scan_mux: RTL and testbench

- Parametrised, registered N:1 data selector for board display paths. Supersedes the fixed 4:1 8-bit mux.
- Two modes:
  - Manual: channel chosen by switches.
  - Auto-scan: steps through the enabled channels, holding each for a programmable dwell time.
- Feeds the LED/7-seg output stage. Exposes the active channel number and a one-cycle channel-change pulse.

---
 rtl/scan_mux_pkg.sv | 43 ++++
 rtl/scan_mux_if.sv | 28 ++
 rtl/scan_mux_dwell_timer.sv | 34 +++
 rtl/scan_mux.sv | 102 ++++++++++
 tb/tb_scan_mux.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg
//   Shared definitions for the scan_mux display selector:
//   - mode input encoding (MODE_MANUAL / MODE_SCAN)
//   - controller state encoding (MANUAL / SCAN / HOLD)
//   - next_enabled(): rotating-priority search for the next enabled channel
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // The search below works on a fixed 16-bit mask so it can live in the
  // package independent of any one instance's CHANNELS value.
  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Returns the first enabled channel strictly above cur (wrapping n-1 -> 0).
  // The last candidate examined is cur itself, so a lone enabled channel
  // maps onto itself. An all-zero mask returns cur unchanged.
  function automatic logic [3:0] next_enabled(input logic [15:0] en,
                                               input logic [3:0]  cur,
                                               input int          n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= MAX_CHANNELS; i++) begin
      idx = int'(cur) + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n) && (idx < MAX_CHANNELS) && en[idx[3:0]]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// scan_mux_if
//   Bundles the channel data, controls and display outputs of scan_mux.
//   master : drives data_in, sel, mode, freeze, ch_en; observes led, ch_out, ch_change
//   slave  : the selector itself (inputs/outputs reversed)
interface scan_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      freeze;
  logic [CHANNELS-1:0]       ch_en;
  logic [WIDTH-1:0]          led;
  logic [SEL_W-1:0]          ch_out;
  logic                      ch_change;

  modport master (
    output data_in, sel, mode, freeze, ch_en,
    input  led, ch_out, ch_change
  );

  modport slave (
    input  data_in, sel, mode, freeze, ch_en,
    output led, ch_out, ch_change
  );
endinterface

// File: rtl/scan_mux_dwell_timer.sv
// scan_mux_dwell_timer
//   Dwell counter for auto-scan. Counts 0..DWELL-1 while enabled, wraps to 0.
//   clk, rst_n : clock, async active-low reset
//   en_i       : count this cycle
//   clr_i      : force the count to 0 (has priority over en_i)
//   tc_o       : high on an enabled cycle whose count is DWELL-1
module scan_mux_dwell_timer #(
  parameter int DWELL = 4,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (tc_o) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux
//   Registered N:1 display selector with manual and auto-scan modes.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): data_in/sel/mode/freeze/ch_en in; led/ch_out/ch_change out
//   led is the data of the channel that ch_out will show after the same edge,
//   so the two outputs are always consistent.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_mux_if.slave  bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ch_out_q, ch_out_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             ch_change_q, ch_change_d;

  logic             tmr_en, tmr_clr, tmr_tc;
  logic             led_blank;
  logic [15:0]      en_pad;
  logic             sel_ok;
  logic [SEL_W-1:0] next_ch;
  logic [WIDTH-1:0] chan [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign chan[gi] = bus.data_in[gi*WIDTH +: WIDTH];
  end

  assign en_pad  = 16'(bus.ch_en);
  assign sel_ok  = int'(bus.sel) < CHANNELS;
  assign next_ch = SEL_W'(next_enabled(en_pad, 4'(ch_out_q), CHANNELS));

  scan_mux_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tmr_en),
    .clr_i (tmr_clr),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    ch_out_d  = ch_out_q;
    led_blank = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;
    if (bus.mode == MODE_MANUAL) begin
      // mode=0 overrides freeze and any pending dwell expiry
      state_d = MANUAL;
      tmr_clr = 1'b1;
      if (sel_ok) ch_out_d = bus.sel;
    end else if (state_q == MANUAL) begin
      // entry edge: scanning starts from the channel already shown
      state_d = SCAN;
      tmr_clr = 1'b1;
    end else if (bus.freeze) begin
      // freeze beats a same-edge expiry; count stays where it is
      state_d = HOLD;
    end else begin
      state_d = SCAN;
      if (en_pad == 16'd0) begin
        tmr_clr   = 1'b1;
        led_blank = 1'b1;
      end else if (!en_pad[ch_out_q]) begin
        // current channel was just disabled: leave it without waiting
        tmr_clr  = 1'b1;
        ch_out_d = next_ch;
      end else begin
        tmr_en = 1'b1;
        if (tmr_tc) ch_out_d = next_ch;
      end
    end
    led_d       = led_blank ? '0 : chan[ch_out_d];
    ch_change_d = (ch_out_d != ch_out_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MANUAL;
      ch_out_q    <= '0;
      led_q       <= '0;
      ch_change_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_out_q    <= ch_out_d;
      led_q       <= led_d;
      ch_change_q <= ch_change_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.ch_out    = ch_out_q;
  assign bus.ch_change = ch_change_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux
//   Self-checking bench: a 4-channel instance checked every cycle against a
//   rule-level model, plus a 3-channel instance for the out-of-range select.
module tb_scan_mux;

  localparam int DW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  scan_mux_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus  ();
  scan_mux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus3 ();

  scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_vec = 0;
  int n_err = 0;

  // model: phase 0 = manual, 1 = scanning, 2 = frozen
  int         m_ph, m_ch, m_cnt;
  logic [7:0] m_led;
  logic       m_chg;
  int         x_ph, x_ch, x_cnt;
  logic [7:0] x_led;
  logic       x_chg;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] led;
    logic [1:0] ch;
    logic       chg;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_of(input int k);
    logic [31:0] d;
    d = bus.data_in;
    return d[k*8 +: 8];
  endfunction

  // first enabled channel after cur, going round the ring; cur if none other
  function automatic int ring_next(input logic [3:0] en, input int cur);
    for (int i = 1; i <= 4; i++)
      if (en[(cur + i) % 4]) return (cur + i) % 4;
    return cur;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ch = 0; m_cnt = 0; m_led = 8'h00; m_chg = 1'b0;
  endtask

  task automatic model_calc();
    logic blank;
    blank = 1'b0;
    x_ph = m_ph; x_ch = m_ch; x_cnt = m_cnt;
    if (!bus.mode) begin
      x_ph = 0; x_cnt = 0;
      x_ch = int'(bus.sel);
    end else if (m_ph == 0) begin
      x_ph = 1; x_cnt = 0;
    end else if (bus.freeze) begin
      x_ph = 2;
    end else begin
      x_ph = 1;
      if (bus.ch_en == 4'b0000) begin
        x_cnt = 0; blank = 1'b1;
      end else if (!bus.ch_en[m_ch]) begin
        x_cnt = 0; x_ch = ring_next(bus.ch_en, m_ch);
      end else if (m_cnt == DW - 1) begin
        x_cnt = 0; x_ch = ring_next(bus.ch_en, m_ch);
      end else begin
        x_cnt = m_cnt + 1;
      end
    end
    x_led = blank ? 8'h00 : chan_of(x_ch);
    x_chg = (x_ch != m_ch);
  endtask

  task automatic tick();
    model_calc();
    @(posedge clk);
    #1;
    m_ph = x_ph; m_ch = x_ch; m_cnt = x_cnt; m_led = x_led; m_chg = x_chg;
    check("model_led", 32'(bus.led), 32'(m_led));
    check("model_ch_out", 32'(bus.ch_out), 32'(m_ch));
    check("model_ch_change", 32'(bus.ch_change), 32'(m_chg));
  endtask

  initial begin
    bus.data_in = {8'hA5, 8'h33, 8'h22, 8'h11};
    bus.sel = 2'd0; bus.mode = 1'b0; bus.freeze = 1'b0; bus.ch_en = 4'b1111;
    bus3.data_in = {8'h0C, 8'h0B, 8'h0A};
    bus3.sel = 2'd0; bus3.mode = 1'b0; bus3.freeze = 1'b0; bus3.ch_en = 3'b111;

    // power-on reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", 32'(bus.led), 32'h0);
    check("rst_ch_out", 32'(bus.ch_out), 32'h0);
    check("rst_ch_change", 32'(bus.ch_change), 32'h0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // manual sweep from a table, each select held for two cycles
    vecs[0] = '{2'd0, 8'h11, 2'd0, 1'b0};
    vecs[1] = '{2'd1, 8'h22, 2'd1, 1'b1};
    vecs[2] = '{2'd2, 8'h33, 2'd2, 1'b1};
    vecs[3] = '{2'd3, 8'hA5, 2'd3, 1'b1};
    for (int v = 0; v < 4; v++) begin
      bus.sel = vecs[v].sel;
      tick();
      check("man_led", 32'(bus.led), 32'(vecs[v].led));
      check("man_ch_out", 32'(bus.ch_out), 32'(vecs[v].ch));
      check("man_ch_change", 32'(bus.ch_change), 32'(vecs[v].chg));
      tick();
      check("man_pulse_width", 32'(bus.ch_change), 32'h0);
      $display("manual sel=%0d led=%02h ch_out=%0d", vecs[v].sel, bus.led, bus.ch_out);
    end

    // live data tracking on ch2
    bus.sel = 2'd2;
    tick();
    for (int i = 0; i < 256; i++) begin
      bus.data_in[16 +: 8] = 8'(i);
      tick();
      check("track_ch2", 32'(bus.led), 32'(i));
    end
    $display("ch2 tracking sweep done");

    // out-of-range select on the 3-channel instance
    bus3.sel = 2'd1;
    tick();
    check("ch3_sel1", 32'(bus3.ch_out), 32'd1);
    check("ch3_led1", 32'(bus3.led), 32'h0B);
    bus3.sel = 2'd3;
    tick();
    check("ch3_sel3_hold", 32'(bus3.ch_out), 32'd1);
    check("ch3_sel3_led", 32'(bus3.led), 32'h0B);
    check("ch3_sel3_nochg", 32'(bus3.ch_change), 32'h0);
    $display("3-channel sel=3 ch_out=%0d", bus3.ch_out);

    // auto-scan wrap with all channels enabled
    bus.data_in = {8'hA5, 8'h33, 8'h22, 8'h11};
    bus.sel = 2'd0;
    tick();
    bus.mode = 1'b1;
    tick();
    check("scan_entry_ch", 32'(bus.ch_out), 32'd0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      check("scan_ch", 32'(bus.ch_out), 32'((t / 4) % 4));
      check("scan_chg", 32'(bus.ch_change), 32'((t % 4) == 0));
    end
    $display("auto-scan wrap done ch_out=%0d", bus.ch_out);

    // mask skip
    bus.ch_en = 4'b1010;
    tick();
    check("mask_leave_ch0", 32'(bus.ch_out), 32'd1);
    for (int t = 0; t < 4; t++) tick();
    check("mask_ch3", 32'(bus.ch_out), 32'd3);
    for (int t = 0; t < 4; t++) tick();
    check("mask_wrap_ch1", 32'(bus.ch_out), 32'd1);
    bus.ch_en = 4'b0000;
    tick();
    check("mask_none_led", 32'(bus.led), 32'h0);
    check("mask_none_ch", 32'(bus.ch_out), 32'd1);
    tick();
    bus.ch_en = 4'b1000;
    tick();
    check("mask_cur_disabled", 32'(bus.ch_out), 32'd3);
    for (int t = 0; t < 6; t++) begin
      tick();
      check("single_en_nochg", 32'(bus.ch_change), 32'h0);
    end
    $display("mask skip done ch_out=%0d", bus.ch_out);

    // freeze at count 2 on ch1
    bus.ch_en = 4'b1111; bus.mode = 1'b0; bus.sel = 2'd1;
    tick();
    bus.mode = 1'b1;
    tick();
    tick(); tick();
    bus.freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in[8 +: 8] = 8'h40 + 8'(i);
      tick();
      check("frz_ch", 32'(bus.ch_out), 32'd1);
      check("frz_led", 32'(bus.led), 32'(8'h40 + 8'(i)));
    end
    bus.freeze = 1'b0;
    tick();
    check("rel_ch_1st", 32'(bus.ch_out), 32'd1);
    tick();
    check("rel_ch_2nd", 32'(bus.ch_out), 32'd2);
    check("rel_chg_2nd", 32'(bus.ch_change), 32'h1);
    tick(); tick(); tick();
    bus.freeze = 1'b1;
    tick();
    check("frz_expiry_ch", 32'(bus.ch_out), 32'd2);
    check("frz_expiry_nochg", 32'(bus.ch_change), 32'h0);
    bus.mode = 1'b0; bus.sel = 2'd3;
    tick();
    check("override_ch", 32'(bus.ch_out), 32'd3);
    check("override_chg", 32'(bus.ch_change), 32'h1);
    bus.freeze = 1'b0;
    $display("freeze and mode override done ch_out=%0d", bus.ch_out);

    // randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(31) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(7) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(15) == 0) bus.ch_en = 4'($urandom);
      bus.sel = 2'($urandom);
      bus.data_in = 32'($urandom);
      tick();
    end
    $display("random run done");

    // reset asserted mid-scan on ch2
    bus.data_in = {8'hA5, 8'h33, 8'h22, 8'h11};
    bus.freeze = 1'b0; bus.ch_en = 4'b1111; bus.mode = 1'b0; bus.sel = 2'd2;
    tick();
    bus.mode = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_ch", 32'(bus.ch_out), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(bus.led), 32'h0);
    check("mid_rst_ch_out", 32'(bus.ch_out), 32'h0);
    check("mid_rst_ch_change", 32'(bus.ch_change), 32'h0);
    model_reset();
    bus.mode = 1'b0; bus.sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_led", 32'(bus.led), 32'h11);
    $display("mid-scan reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
